ram_bist_ctrl: RTL

Built-in self-test sequencer for `single_port_ram`. It drives the RAM's write-enable, address and write-data ports, and checks the RAM's read data. It sits directly in front of the RAM and behind it. It runs two full-depth write/read passes (true pattern, then inverted pattern) and reports pass/fail, error count and first failing address to the system controller.

---
 rtl/ram_bist_pkg.sv | 33 +++
 rtl/ram_bist_chk.sv | 96 +++++++++
 rtl/ram_bist_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// ============================================================================
// Module  : ram_bist_pkg
// Brief   : Shared FSM encoding, read-latency limits and test pattern for the RAM BIST.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_bist_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int PAT_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Callers keep the low DWIDTH bits, which gives the mod 2^DWIDTH wrap.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] addr,
                                               input logic             pass_idx);
    logic [PAT_W-1:0] base;
    base = seed + addr;
    return pass_idx ? ~base : base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bist_chk.sv
// ============================================================================
// Module  : ram_bist_chk
// Brief   : Read-latency delay line, data comparator, error counter and first-error latch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_bist_chk #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              vld_i,
  input  logic [DWIDTH-1:0] exp_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic              pass_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic              mismatch_o,
  output logic [AWIDTH+1:0] err_cnt_o,
  output logic [AWIDTH-1:0] first_err_addr_o,
  output logic              first_err_pass_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] pass_q;
  logic [DWIDTH-1:0] exp_q  [RD_LAT];
  logic [AWIDTH-1:0] addr_q [RD_LAT];

  logic [AWIDTH+1:0] err_cnt_q, err_cnt_d;
  logic [AWIDTH-1:0] fea_q, fea_d;
  logic              fep_q, fep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      pass_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      pass_q[0] <= pass_i;
      exp_q[0]  <= exp_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pass_q[i] <= pass_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign mismatch_o = vld_q[RD_LAT-1] && (rd_data_i != exp_q[RD_LAT-1]);

  // err_cnt cannot wrap, so a zero count marks the first mismatch of the test.
  always_comb begin
    err_cnt_d = err_cnt_q;
    fea_d     = fea_q;
    fep_d     = fep_q;
    if (clear_i) begin
      err_cnt_d = '0;
      fea_d     = '0;
      fep_d     = 1'b0;
    end else if (mismatch_o) begin
      err_cnt_d = err_cnt_q + (AWIDTH+2)'(1);
      if (err_cnt_q == '0) begin
        fea_d = addr_q[RD_LAT-1];
        fep_d = pass_q[RD_LAT-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      fea_q     <= '0;
      fep_q     <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      fea_q     <= fea_d;
      fep_q     <= fep_d;
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = fea_q;
  assign first_err_pass_o = fep_q;

endmodule

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// Module  : ram_bist_ctrl
// Brief   : Two-pass (true/inverted) write/read BIST sequencer for a single-port RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 256,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AWIDTH+1:0] err_cnt,
  output logic [AWIDTH-1:0] first_err_addr,
  output logic              first_err_pass,
  output logic              ram_wr_en,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wr_data,
  input  logic [DWIDTH-1:0] ram_rd_data
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("ram_bist_ctrl: RD_LAT out of range");
  end
  if (DWIDTH >= PAT_W || (1 << AWIDTH) != DEPTH) begin : g_bad_geometry
    $error("ram_bist_ctrl: unsupported DWIDTH/DEPTH/AWIDTH combination");
  end

  localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              pidx_q, pidx_d;
  logic [DWIDTH-1:0] seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              we_q, we_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              w_clear;
  logic              w_mismatch;
  logic [PAT_W-1:0]  w_wpat, w_rpat;
  logic              w_unused_pat;

  // Write data is built from next-state values so it lines up with the registered address.
  assign w_wpat       = pattern(PAT_W'(seed_d), PAT_W'(cnt_d), pidx_d);
  assign w_rpat       = pattern(PAT_W'(seed_q), PAT_W'(cnt_q), pidx_q);
  assign w_unused_pat = ^{w_wpat[PAT_W-1:DWIDTH], w_rpat[PAT_W-1:DWIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    pidx_d  = pidx_q;
    seed_d  = seed_q;
    w_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR;
          cnt_d   = '0;
          pidx_d  = 1'b0;
          seed_d  = seed;
          w_clear = 1'b1;
        end
      end
      S_WR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      S_RD: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (!pidx_q) begin
            pidx_d  = 1'b1;
            state_d = S_WR;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The last compare lands on the same edge that enters DONE, so fold it into pass.
  always_comb begin
    busy_d  = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    we_d    = (state_d == S_WR);
    wdata_d = (state_d == S_WR) ? w_wpat[DWIDTH-1:0] : wdata_q;
    pass_d  = pass_q;
    if (w_clear) begin
      pass_d = 1'b0;
    end else if (state_d == S_DONE) begin
      pass_d = (err_cnt == '0) && !w_mismatch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      pidx_q  <= 1'b0;
      seed_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      pidx_q  <= pidx_d;
      seed_q  <= seed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  ram_bist_chk #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (w_clear),
    .vld_i            (state_q == S_RD),
    .exp_i            (w_rpat[DWIDTH-1:0]),
    .addr_i           (cnt_q),
    .pass_i           (pidx_q),
    .rd_data_i        (ram_rd_data),
    .mismatch_o       (w_mismatch),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .first_err_pass_o (first_err_pass)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign ram_wr_en   = we_q;
  assign ram_addr    = cnt_q;
  assign ram_wr_data = wdata_q;

endmodule

`default_nettype wire
